// File: rtl/mem_arbiter.sv
// Arbitrates N consumer read/write channels onto one memory port, one transaction in flight.
// Optional MEM_ARB_ROUND_ROBIN_EN rotates priority past each grant; otherwise lowest index wins.

module mem_arbiter_lane #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rd_done,
  input  logic                 i_rd_rel,
  input  logic                 i_wr_done,
  input  logic                 i_wr_rel,
  input  logic [DATA_BITS-1:0] i_mem_rdata,
  output logic                 o_rd_rdy,
  output logic                 o_wr_rdy,
  output logic [DATA_BITS-1:0] o_rdata
);
  logic                 r_rd_rdy, r_wr_rdy;
  logic [DATA_BITS-1:0] r_rdata;

  // Read data is only overwritten by this channel's own completions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_rdy <= 1'b0;
      r_wr_rdy <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (i_rd_done) begin
        r_rd_rdy <= 1'b1;
        r_rdata  <= i_mem_rdata;
      end else if (i_rd_rel) begin
        r_rd_rdy <= 1'b0;
      end
      if (i_wr_done)     r_wr_rdy <= 1'b1;
      else if (i_wr_rel) r_wr_rdy <= 1'b0;
    end
  end

  assign o_rd_rdy = r_rd_rdy;
  assign o_wr_rdy = r_wr_rdy;
  assign o_rdata  = r_rdata;
endmodule

module mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready
);
  localparam int IW = $clog2(NUM_CONSUMERS);
  typedef logic [IW-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t               r_state, w_state_nxt;
  idx_t                 r_idx, r_ptr;
  logic                 r_mem_rd_vld, r_mem_wr_vld;
  logic [ADDR_BITS-1:0] r_mem_rd_addr, r_mem_wr_addr;
  logic [DATA_BITS-1:0] r_mem_wr_data;

  logic                 w_found, w_gnt_rd, w_release;
  idx_t                 w_gnt_idx, w_c;
  logic [IW:0]          w_sum;

  // Rotating scan starting at the priority pointer; first requester wins, read before write.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_rd  = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_c       = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_CONSUMERS)) w_sum = w_sum - (IW+1)'(NUM_CONSUMERS);
      w_c = w_sum[IW-1:0];
      if (!w_found && (consumer_read_valid[w_c] || consumer_write_valid[w_c])) begin
        w_found   = 1'b1;
        w_gnt_idx = w_c;
        w_gnt_rd  = consumer_read_valid[w_c];
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  idx_t w_ptr_nxt;
  assign w_ptr_nxt = (w_gnt_idx == idx_t'(NUM_CONSUMERS-1)) ? '0 : w_gnt_idx + idx_t'(1);
`endif

  assign w_release =
    ((r_state == READ_RELAYING)  && !consumer_read_valid[r_idx]  && !mem_read_ready) ||
    ((r_state == WRITE_RELAYING) && !consumer_write_valid[r_idx] && !mem_write_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:           if (w_found) w_state_nxt = w_gnt_rd ? READ_WAITING : WRITE_WAITING;
      READ_WAITING:   if (mem_read_ready)  w_state_nxt = READ_RELAYING;
      WRITE_WAITING:  if (mem_write_ready) w_state_nxt = WRITE_RELAYING;
      READ_RELAYING,
      WRITE_RELAYING: if (w_release) w_state_nxt = IDLE;
      default:        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_ptr         <= '0;
      r_mem_rd_vld  <= 1'b0;
      r_mem_wr_vld  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_idx <= w_gnt_idx;
          if (w_gnt_rd) begin
            r_mem_rd_vld  <= 1'b1;
            r_mem_rd_addr <= consumer_read_address[w_gnt_idx];
          end else begin
            r_mem_wr_vld  <= 1'b1;
            r_mem_wr_addr <= consumer_write_address[w_gnt_idx];
            r_mem_wr_data <= consumer_write_data[w_gnt_idx];
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          r_ptr <= w_ptr_nxt;
`endif
        end
        READ_WAITING:  if (mem_read_ready)  r_mem_rd_vld <= 1'b0;
        WRITE_WAITING: if (mem_write_ready) r_mem_wr_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
      logic w_sel;
      assign w_sel = (r_idx == idx_t'(g));
      mem_arbiter_lane #(.DATA_BITS(DATA_BITS)) u_lane (
        .clk         (clk),
        .reset       (reset),
        .i_rd_done   (w_sel && (r_state == READ_WAITING)  && mem_read_ready),
        .i_rd_rel    (w_sel && (r_state == READ_RELAYING) && w_release),
        .i_wr_done   (w_sel && (r_state == WRITE_WAITING) && mem_write_ready),
        .i_wr_rel    (w_sel && (r_state == WRITE_RELAYING) && w_release),
        .i_mem_rdata (mem_read_data),
        .o_rd_rdy    (consumer_read_ready[g]),
        .o_wr_rdy    (consumer_write_ready[g]),
        .o_rdata     (consumer_read_data[g])
      );
    end
  endgenerate

  assign mem_read_valid    = r_mem_rd_vld;
  assign mem_read_address  = r_mem_rd_addr;
  assign mem_write_valid   = r_mem_wr_vld;
  assign mem_write_address = r_mem_wr_addr;
  assign mem_write_data    = r_mem_wr_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios and random traffic.
// Build with or without MEM_ARB_ROUND_ROBIN_EN; the priority scenario follows the macro.

module tb_mem_arbiter;
  localparam int N = 4, AB = 8, DB = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0]         crv = '0, cwv = '0;
  logic [N-1:0][AB-1:0] cra = '0, cwa = '0;
  logic [N-1:0][DB-1:0] cwd = '0;
  logic [N-1:0]         consumer_read_ready, consumer_write_ready;
  logic [N-1:0][DB-1:0] consumer_read_data;
  logic                 mem_read_valid, mem_write_valid;
  logic [AB-1:0]        mem_read_address, mem_write_address;
  logic [DB-1:0]        mem_write_data;
  logic                 mrd_rdy = 1'b0, mwr_rdy = 1'b0;
  logic [DB-1:0]        mrd_data = '0;
  logic [DB-1:0]        mem [256];

  int n_chk = 0, n_err = 0;
  int rd_lat = 0, wr_lat = 0, lat_max = 1;
  logic [N-1:0] hold_rd = '0;
  int done_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mrd_rdy), .mem_read_data(mrd_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mwr_rdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record (in flight / completed awaiting release).
  bit            m_busy = 0, m_done = 0, m_isrd = 0;
  int            m_ch = 0, m_ptr = 0;
  logic [AB-1:0] m_addr = '0;
  logic [DB-1:0] m_wdata = '0;
  logic [DB-1:0] m_rdata [N] = '{default: '0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_isrd = 0; m_ch = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_rdata[i] = '0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!m_busy && (crv[c] || cwv[c])) begin
          m_busy = 1; m_done = 0; m_ch = c; m_isrd = crv[c];
          m_addr = m_isrd ? cra[c] : cwa[c];
          m_wdata = cwd[c];
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_ptr = (c + 1) % N;
`endif
        end
      end
    end else if (!m_done) begin
      if (m_isrd ? mrd_rdy : mwr_rdy) begin
        m_done = 1;
        if (m_isrd) m_rdata[m_ch] = mrd_data;
      end
    end else if (!(m_isrd ? crv[m_ch] : cwv[m_ch]) && !(m_isrd ? mrd_rdy : mwr_rdy)) begin
      m_busy = 0;
    end
  end

  always @(posedge clk) begin
    bit ev_rd, ev_wr;
    #3;
    ev_rd = m_busy && !m_done && m_isrd;
    ev_wr = m_busy && !m_done && !m_isrd;
    chk("cmp_rd_valid", mem_read_valid, ev_rd);
    if (ev_rd) chk("cmp_rd_addr", mem_read_address, m_addr);
    chk("cmp_wr_valid", mem_write_valid, ev_wr);
    if (ev_wr) begin
      chk("cmp_wr_addr", mem_write_address, m_addr);
      chk("cmp_wr_data", mem_write_data, m_wdata);
    end
    chk("cmp_rd_ready", consumer_read_ready,
        (m_busy && m_done && m_isrd) ? 32'(1 << m_ch) : 32'd0);
    chk("cmp_wr_ready", consumer_write_ready,
        (m_busy && m_done && !m_isrd) ? 32'(1 << m_ch) : 32'd0);
    for (int i = 0; i < N; i++) chk("cmp_rd_data", consumer_read_data[i], m_rdata[i]);
  end

  // One cycle: memory responder, then consumer agents (record completion, drop valid, re-raise held).
  task automatic cyc();
    @(negedge clk);
    if (mrd_rdy) mrd_rdy = 1'b0;
    else if (mem_read_valid) begin
      if (rd_lat == 0) begin
        mrd_rdy = 1'b1; mrd_data = mem[mem_read_address];
        rd_lat = $urandom_range(0, lat_max);
      end else rd_lat--;
    end
    if (mwr_rdy) mwr_rdy = 1'b0;
    else if (mem_write_valid) begin
      if (wr_lat == 0) begin
        mwr_rdy = 1'b1; mem[mem_write_address] = mem_write_data;
        wr_lat = $urandom_range(0, lat_max);
      end else wr_lat--;
    end
    for (int i = 0; i < N; i++) begin
      if (consumer_read_ready[i] && crv[i])  begin done_q.push_back(i*2);   crv[i] = 1'b0; end
      if (consumer_write_ready[i] && cwv[i]) begin done_q.push_back(i*2+1); cwv[i] = 1'b0; end
      if (hold_rd[i] && !crv[i] && !consumer_read_ready[i]) crv[i] = 1'b1;
    end
  endtask

  task automatic run_until(input int n);
    int t = 0;
    while (done_q.size() < n && t < 200) begin cyc(); t++; end
    if (done_q.size() < n) chk("timeout_completions", done_q.size(), n);
  endtask

  initial begin
    int kind, t;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 1);
    mem[16] = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", mem_read_valid, 0);
    chk("rst_wr_valid", mem_write_valid, 0);
    chk("rst_ready", {consumer_read_ready, consumer_write_ready}, 0);
    chk("rst_rd_data", 32'(consumer_read_data != '0), 0);
    reset = 1'b1;
    cyc();

    // Priority behaviour (pointer is 0 straight after reset).
`ifdef MEM_ARB_ROUND_ROBIN_EN
    crv = 4'hF;
    run_until(4);
    for (int k = 0; k < 4; k++) if (done_q.size() > k) chk("rr_order", done_q[k], k*2);
    done_q.delete();
    repeat (3) cyc();
    crv[0] = 1'b1;
    run_until(1);
    repeat (2) cyc();
    done_q.delete();
    crv[1:0] = 2'b11;
    run_until(2);
    if (done_q.size() >= 2) begin
      chk("rr_restart_first", done_q[0], 2);
      chk("rr_restart_second", done_q[1], 0);
    end
`else
    hold_rd = 4'b1001;
    crv = 4'b1001;
    run_until(3);
    hold_rd = '0;
    run_until(4);
    for (int k = 0; k < 3; k++) if (done_q.size() > k) chk("fixed_ch0_first", done_q[k], 0);
    if (done_q.size() > 3) chk("fixed_ch3_last", done_q[3], 6);
`endif
    repeat (3) cyc();
    done_q.delete();

    // Single read on channel 2.
    rd_lat = 0;
    crv[2] = 1'b1; cra[2] = 8'h10;
    cyc();
    chk("rd_valid_rise", mem_read_valid, 1);
    chk("rd_addr", mem_read_address, 8'h10);
    run_until(1);
    if (done_q.size() > 0) chk("rd_channel", done_q[0], 4);
    chk("rd_ready_ch2", consumer_read_ready, 4'b0100);
    chk("rd_data_ch2", consumer_read_data[2], 16'h1234);
    cyc();
    chk("rd_ready_drop", consumer_read_ready, 0);
    repeat (2) cyc();
    done_q.delete();

    // Single write on channel 1, then read it back through channel 0.
    wr_lat = 2;
    cwv[1] = 1'b1; cwa[1] = 8'h20; cwd[1] = 16'hBEEF;
    cyc();
    chk("wr_valid_rise", mem_write_valid, 1);
    chk("wr_addr", mem_write_address, 8'h20);
    chk("wr_data", mem_write_data, 16'hBEEF);
    cyc();
    chk("wr_held", {mem_write_valid, mem_write_address, mem_write_data}, {1'b1, 8'h20, 16'hBEEF});
    run_until(1);
    if (done_q.size() > 0) chk("wr_channel", done_q[0], 3);
    chk("wr_ready_ch1", consumer_write_ready, 4'b0010);
    repeat (3) cyc();
    done_q.delete();
    crv[0] = 1'b1; cra[0] = 8'h20;
    run_until(1);
    chk("readback", consumer_read_data[0], 16'hBEEF);
    chk("other_ch_kept", consumer_read_data[2], 16'h1234);
    repeat (3) cyc();
    done_q.delete();

    // Read and write on the same channel: read first.
    crv[0] = 1'b1; cra[0] = 8'h10;
    cwv[0] = 1'b1; cwa[0] = 8'h30; cwd[0] = 16'h5A5A;
    run_until(2);
    if (done_q.size() >= 2) begin
      chk("rw_first_read", done_q[0], 0);
      chk("rw_then_write", done_q[1], 1);
    end
    chk("rw_mem", mem[8'h30], 16'h5A5A);
    repeat (3) cyc();
    done_q.delete();

    // Reset while the read is waiting on memory.
    rd_lat = 5;
    crv[2] = 1'b1; cra[2] = 8'h11;
    cyc();
    chk("rstw_waiting", mem_read_valid, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_rd_valid", mem_read_valid, 0);
    chk("rstw_ready", {consumer_read_ready, consumer_write_ready}, 0);
    chk("rstw_rd_data", 32'(consumer_read_data != '0), 0);
    chk("rstw_addr", mem_read_address, 0);
    crv = '0; cwv = '0; mrd_rdy = 1'b0; mwr_rdy = 1'b0; rd_lat = 0; wr_lat = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rstw_no_ready", consumer_read_ready, 0);
    end
    chk("rstw_no_completion", done_q.size(), 0);

    // Random traffic.
    lat_max = 3;
    for (int c = 0; c < 1500; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (!crv[i] && !cwv[i] && !consumer_read_ready[i] && !consumer_write_ready[i]
            && $urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 2);
          cra[i] = 8'($urandom_range(0, 15));
          cwa[i] = 8'($urandom_range(0, 15));
          cwd[i] = 16'($urandom);
          crv[i] = (kind != 1);
          cwv[i] = (kind != 0);
        end
      end
    end
    t = 0;
    while ((crv != '0 || cwv != '0 || mem_read_valid || mem_write_valid) && t < 200) begin
      cyc(); t++;
    end
    chk("drain_done", 32'(crv == '0 && cwv == '0), 1);
    chk("rand_activity", 32'(done_q.size() > 100), 1);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
